// File: rtl/encoder_8_3_pipe_if.sv
// Valid/ready bundle for the pipelined one-hot encoder.
// Master drives vectors in and accepts results; slave is the encoder.
interface encoder_8_3_pipe_if #(
  parameter int N = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [(1<<N)-1:0]  in;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out;
  logic               out_zero;
  logic               out_multi;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_zero, out_multi
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_zero, out_multi
  );
endinterface

// File: rtl/encoder_8_3_pipe.sv
// Two-stage one-hot to binary encoder with zero/multi-hot flags
// and a saturating error counter.
module encoder_8_3_pipe #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  encoder_8_3_pipe_if.slave   bus,
  input  logic                err_clr,
  output logic [7:0]          err_count
);
  localparam int W = 1 << N;

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_vec_q, s1_vec_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_q, out_d;
  logic          zero_q, zero_d;
  logic          multi_q, multi_d;
  logic [7:0]    err_q, err_d;

  logic adv;
  logic accept;
  logic out_hs;

  // Lowest set bit wins when several bits are set.
  function automatic logic [N-1:0] lowest(input logic [W-1:0] v);
    lowest = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) lowest = N'(i);
    end
  endfunction

  assign adv    = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign out_hs = out_valid_q && bus.out_ready;

  assign bus.in_ready  = !s1_valid_q || adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_multi = multi_q;
  assign err_count     = err_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_vec_d   = s1_vec_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_vec_d   = bus.in;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d   = lowest(s1_vec_q);
        zero_d  = (s1_vec_q == '0);
        multi_d = |(s1_vec_q & (s1_vec_q - W'(1)));
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (out_hs && (zero_q || multi_q) && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_vec_q    <= s1_vec_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      err_q       <= err_d;
    end
  end
endmodule
